vcm_i2c_writer: RTL

Downstream consumer of the autofocus controller's 16-bit VCM drive word. Whenever the word on `VCM_DATA` differs from the last value successfully written, the block runs a three-byte I2C write to the lens VCM driver: slave address, data MSB, data LSB. It sits between the focus controller and the camera-module I2C pins. Bus timing is generated from the system clock.

---
 rtl/vcm_i2c_writer.sv | 107 ++++++++++
 1 files changed

// File: rtl/vcm_i2c_writer.sv
// vcm_i2c_writer: sends every changed 16-bit VCM drive word to the lens driver as a 3-byte I2C write.
module vcm_i2c_writer #(
    parameter int unsigned CLK_DIV    = 125,
    parameter logic [6:0]  SLAVE_ADDR = 7'h0C
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        EN,
    input  logic [15:0] VCM_DATA,
    input  logic        I2C_SDA_I,
    output logic        I2C_SCL,
    output logic        I2C_SDA_OE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ACK_ERR,
    output logic [15:0] LAST_DATA
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_GAP} state_t;
    localparam logic [9:0] LP_TOP = 10'(CLK_DIV - 1);
    localparam logic [9:0] LP_PRE = 10'(CLK_DIV - 2);
    state_t      r_state;
    logic [9:0]  r_cnt;
    logic [1:0]  r_ph;
    logic [4:0]  r_bit;
    logic [26:0] r_sh;
    logic [15:0] r_word;
    logic        r_nack;
    logic        w_tick;
    logic        w_ack;
    assign w_tick = r_cnt == LP_TOP;
    assign w_ack  = r_bit == 5'd8 || r_bit == 5'd17 || r_bit == 5'd26;
    // r_sh holds the whole frame with 1s in the ACK slots, so ACK bits release SDA
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ph       <= '0;
            r_bit      <= '0;
            r_sh       <= '0;
            r_word     <= '0;
            r_nack     <= 1'b0;
            I2C_SCL    <= 1'b1;
            I2C_SDA_OE <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ACK_ERR    <= 1'b0;
            LAST_DATA  <= 16'hFFFF;
        end else begin
            DONE  <= 1'b0;
            r_cnt <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + 10'd1;
            if (w_tick) r_ph <= r_ph + 2'd1;
            case (r_state)
                S_IDLE: if (EN && VCM_DATA != LAST_DATA) begin
                    r_state    <= S_START;
                    r_ph       <= '0;
                    r_bit      <= '0;
                    r_nack     <= 1'b0;
                    r_word     <= VCM_DATA;
                    r_sh       <= {SLAVE_ADDR, 1'b0, 1'b1, VCM_DATA[15:8], 1'b1, VCM_DATA[7:0], 1'b1};
                    BUSY       <= 1'b1;
                    I2C_SDA_OE <= 1'b1;
                end
                S_START: if (w_tick && r_ph == 2'd1) begin
                    r_state    <= S_BIT;
                    r_ph       <= '0;
                    I2C_SCL    <= 1'b0;
                    I2C_SDA_OE <= ~r_sh[26];
                end
                S_BIT: if (w_tick) begin
                    if (r_ph == 2'd1) I2C_SCL <= 1'b1;
                    if (r_ph == 2'd2 && w_ack && I2C_SDA_I) r_nack <= 1'b1;
                    if (r_ph == 2'd3) begin
                        I2C_SCL <= 1'b0;
                        if (r_nack || r_bit == 5'd26) begin
                            r_state    <= S_STOP;
                            I2C_SDA_OE <= 1'b1;
                        end else begin
                            r_bit      <= r_bit + 5'd1;
                            r_sh       <= r_sh << 1;
                            I2C_SDA_OE <= ~r_sh[25];
                        end
                    end
                end
                S_STOP: if (w_tick) begin
                    I2C_SCL <= 1'b1;
                    if (r_ph == 2'd1) begin
                        r_state    <= S_GAP;
                        r_ph       <= '0;
                        I2C_SDA_OE <= 1'b0;
                    end
                end
                S_GAP: if (r_ph == 2'd3) begin
                    if (r_cnt == LP_PRE) begin
                        DONE    <= 1'b1;
                        ACK_ERR <= r_nack;
                        if (!r_nack) LAST_DATA <= r_word;
                    end
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        BUSY    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
